uart_fifo: RTL
==============

# uart_fifo

Parametrised memory-mapped UART with RX/TX FIFOs, a runtime-programmable baud divisor, and maskable level interrupts. It is the successor to the single-byte `uart` peripheral and sits on the core's registered data bus at a 16-byte window; the top-level decoder drives `csb_i`. `irq_o` feeds the core's `meip_i`.

## Interface
- `SYS_CLK_FREQ`, default 100000000: system clock frequency in Hz.
- `BAUD`, default 9600: baud rate used to compute the reset divisor, `DEFAULT_DIV = SYS_CLK_FREQ/BAUD` (truncated).
- `FIFO_DEPTH`, default 16: entries per FIFO; power of 2, range 2..128.
- `clk_i`  in  1: the single clock; all logic is rising-edge.
- `reset_i`  in  1: asynchronous, active-low reset.
- `rx_i`  in  1: serial input, asynchronous to `clk_i`.
- `csb_i`  in  1: chip select, active-low.
- `wen_i`  in  1: write enable, active-low (0 = write, 1 = read).
- `addr_i`  in  4: byte address within the window; only [3:2] is decoded.
- `data_i`  in  32: write data.
- `wmask_i`  in  4: byte write mask.
- `data_o`  out  32: registered read data.
- `tx_o`  out  1: serial output, idle high.
- `irq_o`  out  1: level interrupt.

## Operation
- A bus access occurs on a rising edge with `csb_i`=0. A register write needs `wen_i`=0 and the relevant byte lane set in `wmask_i`.
- **Offset 0x0, DATA.**
  - Write (lane 0): pushes `data_i[7:0]` into the TX FIFO. If the FIFO is full, the write is ignored.
  - Read: pops the RX FIFO and returns {24'b0, byte}. If the FIFO is empty, it returns 0 and no pointer moves.
- **Offset 0x4, STATUS.**
  - Read-only fields: bit0 rx_nonempty, bit1 rx_full, bit2 tx_full, bit3 tx_empty, [15:8] rx_count, [23:16] tx_count.
  - Sticky fields: bit4 rx_overrun, bit5 frame_err. Each is cleared by writing 1 to that bit (lane 0).
- **Offset 0x8, CTRL.** bit0 rx_irq_en, bit1 tx_irq_en; all other bits read 0.
- **Offset 0xC, DIV.** [15:0] baud divisor in clocks per bit. A written value below 2 is stored as 2.
- Frame format: 8N1, LSB first.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE with the TX FIFO non-empty: pop one byte, latch DIV, go to START.
  - Each state lasts DIV cycles.
  - DATA runs 8 bits; STOP drives `tx_o`=1, then returns to IDLE. IDLE can pop the next byte on the cycle STOP ends, so frames go back-to-back.
- RX FSM (IDLE, START, DATA, STOP):
  - `rx_i` passes through a 2-flop synchronizer.
  - IDLE: a falling edge on the synchronized input latches DIV and goes to START.
  - START: at DIV/2 cycles, if the line is high it is a glitch and the FSM returns to IDLE. Otherwise it proceeds to DATA.
  - DATA: samples 8 bits, one every DIV cycles.
  - STOP: samples once. High pushes the byte. If the FIFO is full, the byte is dropped and rx_overrun is set. Low discards the byte and sets frame_err. The FSM then returns to IDLE.
- `irq_o` = (rx_irq_en & rx_nonempty) | (tx_irq_en & tx_empty).
- Simultaneous RX push and bus pop in the same cycle (including when full): both succeed and the count is unchanged. Simultaneous TX push and FSM pop behave the same way.
- A DIV write in mid-frame takes effect at the next frame start.

## Timing
- Reset values:
  - `tx_o`=1, `irq_o`=0, `data_o`=0.
  - FIFOs empty; both FSMs in IDLE.
  - CTRL=0, DIV=DEFAULT_DIV, sticky bits 0.
- Reset asserted mid-frame: `tx_o` goes to 1 immediately (asynchronously) and any partial RX byte is discarded.
- `data_o` is valid after the access edge and holds until the next read.
- TX latency: after a DATA write at edge N with TX idle, `tx_o` falls at edge N+1. A frame is 10×DIV cycles.
- RX latency: the byte becomes visible in STATUS about 2 + DIV/2 + 9×DIV cycles after the `rx_i` falling edge.
- `irq_o` is combinational from registers, so it updates in the same cycle as the state it reflects.

## Test plan
- **Reset:** assert `reset_i` while TX is busy → `tx_o`=1 immediately. After release: STATUS reads 0x00000008, DIV reads 10416 (0x28B0), `irq_o`=0.
- **TX:**
  - Stimulus: write DIV=16, then DATA=0x55.
  - Expect: `tx_o` low one cycle after the write.
  - Then the bits 1,0,1,0,1,0,1,0, 16 cycles each, then stop high.
  - Total 160 cycles; tx_empty is set at frame start.
- **RX:**
  - Stimulus: DIV=16, CTRL=1, drive 0xA3 on `rx_i`.
  - Expect: `irq_o`=1 and STATUS[0]=1.
  - Reading DATA returns 0x000000A3, after which `irq_o`=0.
  - A 4-cycle low glitch on `rx_i` pushes nothing.
- **Overrun:**
  - Stimulus: send 17 bytes 0x00..0x10 without reading.
  - Expect: rx_count=16, rx_full=1, rx_overrun=1.
  - Reads return 0x00..0x0F in order.
  - Writing 0x10 to STATUS clears the overrun bit.
- **Framing:** send 0x3C with the stop bit low → no push, frame_err=1.
- **TX full:**
  - Stimulus: write 18 bytes back-to-back at DIV=16.
  - Expect: byte 1 goes to the shifter and bytes 2..17 fill the FIFO (tx_full=1). Byte 18 is dropped.
  - 17 frames are observed on `tx_o`.

Source files
------------

// File: rtl/uart_fifo.sv
// Memory-mapped 8N1 UART: RX/TX byte FIFOs, runtime baud divisor, maskable level IRQ.
// Bus reads are registered; DATA reads pop the RX FIFO, DATA writes push the TX FIFO.

module uart_fifo_buf #(
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  logic [7:0]             wdata_i,
  input  logic                   pop_i,
  output logic [7:0]             rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

module uart_fifo #(
  parameter int SYS_CLK_FREQ = 100000000,
  parameter int BAUD         = 9600,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        rx_i,
  input  logic        csb_i,
  input  logic        wen_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  wmask_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        irq_o
);
  localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] DEFAULT_DIV = 16'(SYS_CLK_FREQ / BAUD);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  // ---------------- bus decode / registers ----------------
  logic        wr, rd, sel_data, sel_stat, sel_ctrl, sel_div;
  logic [1:0]  ctrl_q;
  logic [15:0] div_q, div_wdata;
  logic        ovr_q, ferr_q;
  logic [31:0] data_q, rd_mux, status;
  logic        unused_bits;

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_rdata;
  logic [CW-1:0] tx_count;
  logic          rx_push, rx_pop, rx_full, rx_empty, rx_ferr_set, rx_ovr_set;
  logic [7:0]    rx_rdata;
  logic [CW-1:0] rx_count;

  assign wr       = ~csb_i & ~wen_i;
  assign rd       = ~csb_i &  wen_i;
  assign sel_data = (addr_i[3:2] == 2'd0);
  assign sel_stat = (addr_i[3:2] == 2'd1);
  assign sel_ctrl = (addr_i[3:2] == 2'd2);
  assign sel_div  = (addr_i[3:2] == 2'd3);
  assign unused_bits = ^{addr_i[1:0], data_i[31:16], wmask_i[3:2]};

  assign tx_push    = wr & sel_data & wmask_i[0];
  assign rx_pop     = rd & sel_data;
  assign rx_ovr_set = rx_push & rx_full & ~rx_pop;

  assign status = {8'b0, 8'(tx_count), 8'(rx_count), 2'b0,
                   ferr_q, ovr_q, tx_empty, tx_full, rx_full, ~rx_empty};

  always_comb begin
    div_wdata = div_q;
    if (wmask_i[0]) div_wdata[7:0]  = data_i[7:0];
    if (wmask_i[1]) div_wdata[15:8] = data_i[15:8];
  end

  always_comb begin
    rd_mux = '0;
    case (addr_i[3:2])
      2'd0:    rd_mux = rx_empty ? 32'b0 : {24'b0, rx_rdata};
      2'd1:    rd_mux = status;
      2'd2:    rd_mux = {30'b0, ctrl_q};
      default: rd_mux = {16'b0, div_q};
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      ctrl_q <= '0;
      div_q  <= DEFAULT_DIV;
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (wr && sel_ctrl && wmask_i[0]) ctrl_q <= data_i[1:0];
      if (wr && sel_div && |wmask_i[1:0]) div_q <= (div_wdata < 16'd2) ? 16'd2 : div_wdata;
      // A new event wins over a same-cycle clear so it is never lost.
      if (rx_ovr_set) ovr_q <= 1'b1;
      else if (wr && sel_stat && wmask_i[0] && data_i[4]) ovr_q <= 1'b0;
      if (rx_ferr_set) ferr_q <= 1'b1;
      else if (wr && sel_stat && wmask_i[0] && data_i[5]) ferr_q <= 1'b0;
      if (rd) data_q <= rd_mux;
    end
  end

  assign data_o = data_q;
  assign irq_o  = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty);

  uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_txf (
    .clk_i(clk_i), .reset_i(reset_i), .push_i(tx_push), .wdata_i(data_i[7:0]),
    .pop_i(tx_pop), .rdata_o(tx_rdata), .full_o(tx_full), .empty_o(tx_empty),
    .count_o(tx_count)
  );

  uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rxf (
    .clk_i(clk_i), .reset_i(reset_i), .push_i(rx_push), .wdata_i(rx_sh_q),
    .pop_i(rx_pop), .rdata_o(rx_rdata), .full_o(rx_full), .empty_o(rx_empty),
    .count_o(rx_count)
  );

  // ---------------- TX FSM ----------------
  state_e      tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_q, tx_d, tx_tick, tx_load;

  assign tx_tick = (tx_cnt_q == tx_div_q - 16'd1);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DEFAULT_DIV;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_load    = 1'b0;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        tx_load  = ~tx_empty;
      end
      S_START: if (tx_tick) begin
        tx_state_d = S_DATA;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
      end
      S_DATA: if (tx_tick) begin
        tx_cnt_d = '0;
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
      end
      default: if (tx_tick) begin
        // End of stop bit doubles as an idle cycle so frames run back-to-back.
        tx_state_d = S_IDLE;
        tx_cnt_d   = '0;
        tx_load    = ~tx_empty;
      end
    endcase
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_sh_d    = tx_rdata;
      tx_div_d   = div_q;
      tx_cnt_d   = '0;
      tx_state_d = S_START;
    end
  end

  always_comb begin
    tx_d = 1'b1;
    case (tx_state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_o = tx_q;

  // ---------------- RX FSM ----------------
  logic        rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;
  state_e      rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_tick, rx_mid;

  assign rx_fall = rx_s3_q & ~rx_s2_q;
  assign rx_tick = (rx_cnt_q == rx_div_q - 16'd1);
  assign rx_mid  = (rx_cnt_q == {1'b0, rx_div_q[15:1]} - 16'd1);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DEFAULT_DIV;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_s1_q    <= rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) begin
          rx_div_d   = div_q;
          rx_state_d = S_START;
        end
      end
      S_START: if (rx_mid) begin
        // Line back high at mid start bit: a glitch, not a frame.
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_tick) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
      end
      default: if (rx_tick) begin
        rx_cnt_d   = '0;
        rx_state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rx_push     = 1'b0;
    rx_ferr_set = 1'b0;
    if (rx_state_q == S_STOP && rx_tick) begin
      rx_push     = rx_s2_q;
      rx_ferr_set = ~rx_s2_q;
    end
  end
endmodule
